// File: rtl/ccsds_turbo_dec_lextr_tree_if.sv
// Sample bus of the a-posteriori / extrinsic LLR unit.
// The optional saturation counter adds isop / osat_cnt when
// CCSDS_TURBO_DEC_LEXTR_SAT_CNT_EN is defined.
interface ccsds_turbo_dec_lextr_tree_if #(
  parameter int pSTATE_NUM = 16,
  parameter int pMETRIC_W  = 10,
  parameter int pLLR_W     = 5,
  parameter int pEXTR_W    = 6,
  parameter int pTAG_W     = 8
);
  logic                                  iclkena;
  logic                                  ival;
  logic [pSTATE_NUM*2*pMETRIC_W-1:0]     igamma;
  logic [pSTATE_NUM*pMETRIC_W-1:0]       istate;
  logic signed [pLLR_W-1:0]              iLsys;
  logic signed [pLLR_W-1:0]              iLapri;
  logic [pTAG_W-1:0]                     itag;
  logic                                  oval;
  logic [pTAG_W-1:0]                     otag;
  logic signed [pMETRIC_W-1:0]           oLapo;
  logic signed [pEXTR_W-1:0]             oLextr;
`ifdef CCSDS_TURBO_DEC_LEXTR_SAT_CNT_EN
  logic                                  isop;
  logic [15:0]                           osat_cnt;

  modport master (
    output iclkena, ival, igamma, istate, iLsys, iLapri, itag, isop,
    input  oval, otag, oLapo, oLextr, osat_cnt
  );
  modport slave (
    input  iclkena, ival, igamma, istate, iLsys, iLapri, itag, isop,
    output oval, otag, oLapo, oLextr, osat_cnt
  );
`else
  modport master (
    output iclkena, ival, igamma, istate, iLsys, iLapri, itag,
    input  oval, otag, oLapo, oLextr
  );
  modport slave (
    input  iclkena, ival, igamma, istate, iLsys, iLapri, itag,
    output oval, otag, oLapo, oLextr
  );
`endif
endinterface

// File: rtl/ccsds_turbo_dec_lextr_tree.sv
// A-posteriori / extrinsic LLR unit of the CCSDS turbo SISO decoder.
// Pipeline: branch+state metric add -> per-bit max/max* tree -> Lapo
// difference -> scaled, rounded, saturated extrinsic LLR.
// Latency is T+3 enabled cycles, T = ceil(log2(pSTATE_NUM)/pREG_EVERY).
// Optional build macro CCSDS_TURBO_DEC_LEXTR_SAT_CNT_EN adds a
// saturation counter (isop in, osat_cnt out).
module ccsds_turbo_dec_lextr_tree #(
  parameter int pB_nF      = 1,
  parameter int pSTATE_NUM = 16,
  parameter int pMETRIC_W  = 10,
  parameter int pLLR_W     = 5,
  parameter int pEXTR_W    = 6,
  parameter int pMMAX_TYPE = 0,
  parameter int pREG_EVERY = 1,
  parameter int pSCALE_NUM = 6,
  parameter int pTAG_W     = 8
) (
  input logic iclk,
  input logic ireset,
  ccsds_turbo_dec_lextr_tree_if.slave bus
);

  localparam int cLOG = $clog2(pSTATE_NUM);
  localparam int cT   = (cLOG + pREG_EVERY - 1) / pREG_EVERY;
  localparam int cL   = cT + 3;
  localparam int cDW  = pMETRIC_W + 2;   // width of the extrinsic difference
  localparam int cPW  = pMETRIC_W + 6;   // difference times scale (<= 8)

  localparam logic [cPW-1:0]        cSCALE   = cPW'(pSCALE_NUM);
  localparam logic signed [cPW-1:0] cRND     = cPW'(4);
  localparam logic signed [cPW-1:0] cMAX     = cPW'((2 ** (pEXTR_W - 1)) - 1);
  localparam logic signed [cPW-1:0] cMIN     = -cMAX;
  localparam logic [pEXTR_W-1:0]    cOUT_MAX = pEXTR_W'((2 ** (pEXTR_W - 1)) - 1);
  localparam logic [pEXTR_W-1:0]    cOUT_MIN = -cOUT_MAX;

  // Shared trellis successor: recursive encoder with feedback taps on the two
  // oldest register bits (1 + D^3 + D^4 for 16 states).
  function automatic int next_state(input int s, input int b);
    int fb;
    fb = b ^ ((s >> (cLOG - 1)) & 1) ^ ((s >> (cLOG - 2)) & 1);
    return ((s << 1) | fb) & (pSTATE_NUM - 1);
  endfunction

  // max* correction term, indexed by |a-b| in metric LSBs.
  function automatic logic [pMETRIC_W-1:0] bm_mmax1(input logic [pMETRIC_W-1:0] mag);
    logic [pMETRIC_W-1:0] corr;
    if (mag == '0)                     corr = pMETRIC_W'(3);
    else if (mag <= pMETRIC_W'(2))     corr = pMETRIC_W'(2);
    else if (mag <= pMETRIC_W'(5))     corr = pMETRIC_W'(1);
    else                               corr = '0;
    return corr;
  endfunction

  // Modular max: a wins when (a-b) has a clear MSB, ties pick a.
  function automatic logic [pMETRIC_W-1:0] mmax(input logic [pMETRIC_W-1:0] a,
                                                input logic [pMETRIC_W-1:0] b);
    logic [pMETRIC_W-1:0] diff;
    logic [pMETRIC_W-1:0] win;
    logic [pMETRIC_W-1:0] mag;
    diff = a - b;
    win  = diff[pMETRIC_W-1] ? b : a;
    mag  = diff[pMETRIC_W-1] ? (b - a) : diff;
    if (pMMAX_TYPE == 1) win = win + bm_mmax1(mag);
    return win;
  endfunction

  // Sideband carried alongside each sample through the pipeline.
  typedef struct packed {
`ifdef CCSDS_TURBO_DEC_LEXTR_SAT_CNT_EN
    logic              sop;
`endif
    logic [pLLR_W-1:0] lsys;
    logic [pLLR_W-1:0] lapri;
    logic [pTAG_W-1:0] tag;
  } side_t;

  logic [cL-1:0]        val_reg;
  side_t                side_in;
  side_t                side_reg [0:cT+1];
  logic [pMETRIC_W-1:0] bm_next  [0:pSTATE_NUM-1][0:1];
  logic [pMETRIC_W-1:0] bm_reg   [0:pSTATE_NUM-1][0:1];
  // Tree layer outputs; layer 0 is the registered branch metric set.
  logic [pMETRIC_W-1:0] lay      [0:cLOG][0:1][0:pSTATE_NUM-1];
  logic [pMETRIC_W-1:0] lapo_reg;
  logic [pMETRIC_W-1:0] olapo_reg;
  logic [pEXTR_W-1:0]   oextr_reg;
  logic [pTAG_W-1:0]    otag_reg;

  logic [cDW-1:0]        diff_w;
  logic signed [cPW-1:0] prod;
  logic signed [cPW-1:0] rnd_sum;
  logic signed [cPW-1:0] rnd;
  logic [pEXTR_W-1:0]    extr_next;

  assign side_in.lsys  = bus.iLsys;
  assign side_in.lapri = bus.iLapri;
  assign side_in.tag   = bus.itag;
`ifdef CCSDS_TURBO_DEC_LEXTR_SAT_CNT_EN
  assign side_in.sop   = bus.isop;
`endif

  // Valid shift register: one bit per pipeline stage, frozen by iclkena.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      val_reg <= '0;
    end else if (bus.iclkena) begin
      val_reg <= {val_reg[cL-2:0], bus.ival};
    end
  end

  // Sideband delay line; each stage loads only behind a valid sample.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      for (int i = 0; i <= cT + 1; i++) side_reg[i] <= '0;
    end else if (bus.iclkena) begin
      if (bus.ival) side_reg[0] <= side_in;
      for (int i = 1; i <= cT + 1; i++) begin
        if (val_reg[i-1]) side_reg[i] <= side_reg[i-1];
      end
    end
  end

  // Stage 0 adders: gamma plus the state metric of the source/target state.
  genvar gi, gb, gn;
  generate
    for (gi = 0; gi < pSTATE_NUM; gi++) begin : g_bm
      for (gb = 0; gb < 2; gb++) begin : g_bit
        localparam int cIDX = (pB_nF != 0) ? gi : next_state(gi, gb);
        assign bm_next[gi][gb] = bus.igamma[(gi*2+gb)*pMETRIC_W +: pMETRIC_W]
                               + bus.istate[cIDX*pMETRIC_W +: pMETRIC_W];
        assign lay[0][gb][gi]  = bm_reg[gi][gb];
      end
    end
  endgenerate

  // Stage 0 register: branch metrics for both bit hypotheses.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      bm_reg <= '{default: '0};
    end else if (bus.iclkena && bus.ival) begin
      bm_reg <= bm_next;
    end
  end

  // Pairwise reduction tree; a layer is registered every pREG_EVERY layers
  // and always at the root, the rest are plain combinational compares.
  generate
    for (gi = 1; gi <= cLOG; gi++) begin : g_layer
      localparam int cN   = pSTATE_NUM >> gi;
      localparam bit cREG = ((gi % pREG_EVERY) == 0) || (gi == cLOG);
      localparam int cSTG = (gi + pREG_EVERY - 1) / pREG_EVERY;
      for (gb = 0; gb < 2; gb++) begin : g_bit
        for (gn = 0; gn < pSTATE_NUM; gn++) begin : g_node
          if (gn < cN) begin : g_used
            logic [pMETRIC_W-1:0] mm;
            assign mm = mmax(lay[gi-1][gb][2*gn], lay[gi-1][gb][2*gn+1]);
            if (cREG) begin : g_reg
              logic [pMETRIC_W-1:0] node_reg;
              // Tree pipeline register for this node.
              always_ff @(posedge iclk or posedge ireset) begin
                if (ireset) begin
                  node_reg <= '0;
                end else if (bus.iclkena && val_reg[cSTG-1]) begin
                  node_reg <= mm;
                end
              end
              assign lay[gi][gb][gn] = node_reg;
            end else begin : g_comb
              assign lay[gi][gb][gn] = mm;
            end
          end else begin : g_unused
            assign lay[gi][gb][gn] = '0;
          end
        end
      end
    end
  endgenerate

  // Lapo stage: bit-1 winner minus bit-0 winner, modular.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      lapo_reg <= '0;
    end else if (bus.iclkena && val_reg[cT]) begin
      lapo_reg <= lay[cLOG][1][0] - lay[cLOG][0][0];
    end
  end

  // Extrinsic arithmetic: widen, subtract, scale by pSCALE_NUM/8 with
  // round-half-up, then clamp symmetrically so the most negative code never
  // appears.
  always_comb begin
    diff_w = {{2{lapo_reg[pMETRIC_W-1]}}, lapo_reg}
           - {{(cDW-pLLR_W){side_reg[cT+1].lsys[pLLR_W-1]}}, side_reg[cT+1].lsys}
           - {{(cDW-pLLR_W){side_reg[cT+1].lapri[pLLR_W-1]}}, side_reg[cT+1].lapri};
    prod    = {{(cPW-cDW){diff_w[cDW-1]}}, diff_w} * cSCALE;
    rnd_sum = prod + cRND;
    rnd     = rnd_sum >>> 3;
    if (rnd > cMAX)      extr_next = cOUT_MAX;
    else if (rnd < cMIN) extr_next = cOUT_MIN;
    else                 extr_next = rnd[pEXTR_W-1:0];
  end

  // Output stage: Lapo, Lextr and tag change together, hold between valids.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      olapo_reg <= '0;
      oextr_reg <= '0;
      otag_reg  <= '0;
    end else if (bus.iclkena && val_reg[cL-2]) begin
      olapo_reg <= lapo_reg;
      oextr_reg <= extr_next;
      otag_reg  <= side_reg[cT+1].tag;
    end
  end

  assign bus.oval   = val_reg[cL-1];
  assign bus.oLapo  = olapo_reg;
  assign bus.oLextr = oextr_reg;
  assign bus.otag   = otag_reg;

`ifdef CCSDS_TURBO_DEC_LEXTR_SAT_CNT_EN
  logic        sat_w;
  logic [15:0] sat_cnt_reg;

  assign sat_w = (rnd > cMAX) || (rnd < cMIN);

  // Saturation counter: restarts on a start-of-packet sample, else counts
  // saturated outputs and sticks at full scale.
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      sat_cnt_reg <= '0;
    end else if (bus.iclkena && val_reg[cL-2]) begin
      if (side_reg[cT+1].sop)                   sat_cnt_reg <= sat_w ? 16'd1 : 16'd0;
      else if (sat_w && sat_cnt_reg != 16'hFFFF) sat_cnt_reg <= sat_cnt_reg + 16'd1;
    end
  end

  assign bus.osat_cnt = sat_cnt_reg;
`endif

endmodule

// File: doc/ccsds_turbo_dec_lextr_tree.md
Name: ccsds_turbo_dec_Lextr_tree

Overview:
Parametrised a-posteriori / extrinsic LLR unit for the CCSDS turbo SISO decoder. It combines branch metrics with forward or backward state metrics, reduces them per information bit through a pipelined max/max* tree of configurable width and register density, and forms the Lapo difference. It then produces the scaled, saturated extrinsic LLR. It sits after the alpha/beta recursion units and feeds the extrinsic memory and the interleaver.

Parameters:
pB_nF, 0, 1: istate holds alpha[k], added at state index; 0: istate holds beta[k+1], added at trel.nextStates[state][inb]
pSTATE_NUM, 16, trellis states; power of two, 4..64; must equal the shared trellis state count when pB_nF=0
pMETRIC_W, 10, state/branch metric width; modular two's complement
pLLR_W, 5, width of iLsys/iLapri
pEXTR_W, 6, width of oLextr
pMMAX_TYPE, 0, 0: max-log; 1: max* via shared bm_mmax1 correction
pREG_EVERY, 1, tree register density: 1 = register every layer, 2 = every second layer
pSCALE_NUM, 6, extrinsic scale = pSCALE_NUM/8; 1..8
pTAG_W, 8, sideband tag width

Ports:
iclk  in  1  clock
ireset  in  1  asynchronous active-high reset
iclkena  in  1  clock enable; low freezes every register
ival  in  1  input sample valid
igamma  in  pSTATE_NUM*2*pMETRIC_W  gamma_e + opposite-direction metric, indexed [state][inb]
istate  in  pSTATE_NUM*pMETRIC_W  alpha[k] (pB_nF=1) or beta[k+1] (pB_nF=0)
iLsys  in  pLLR_W  systematic channel LLR, signed
iLapri  in  pLLR_W  a-priori LLR, signed
itag  in  pTAG_W  sideband tag, carried with the sample
oval  out  1  output valid
otag  out  pTAG_W  delayed itag
oLapo  out  pMETRIC_W  a-posteriori LLR, signed
oLextr  out  pEXTR_W  extrinsic LLR, signed, saturated

Behaviour:
- Stage 0: bm[s][b] = igamma[s][b] + istate[idx], sum mod 2^pMETRIC_W; idx = s when pB_nF=1, trel.nextStates[s][b] when pB_nF=0.
- Tree: log2(pSTATE_NUM) pairwise layers per bit; pairs are (0,1),(2,3)... then adjacent results. T = ceil(log2(pSTATE_NUM)/pREG_EVERY) register stages; unregistered layers are combinational.
- Comparison is modular: a wins if (a-b) mod 2^pMETRIC_W has MSB 0; ties select a. bm_mmax1 adds the shared correction term.
- Lapo stage: oLapo = tree[1] - tree[0], mod 2^pMETRIC_W.
- Extrinsic stage: d = Lapo - Lsys - Lapri at pMETRIC_W+2 bits, sign-extended; p = d*pSCALE_NUM; r = (p + 4) >>> 3 (round half up); saturate to ±(2^(pEXTR_W-1)-1), so -2^(pEXTR_W-1) never appears.
- Lsys, Lapri and tag travel in delay lines matched to the pipeline.
- Latency L = T + 3 enabled cycles; 7 for defaults. oLapo and oLextr update in the same cycle and are valid when oval=1.
- Valid shift register of length L; each stage's data register loads only when that stage's valid is set. Bubbles pass through, and outputs hold their last value between valids.
- Back-to-back ival accepted every enabled cycle; no backpressure.
- iclkena=0: all registers, including the valid pipe, hold. Cycles with iclkena=0 do not count toward latency.
- Reset: valid pipe, oval, otag, oLapo, oLextr all 0 asynchronously. Reset mid-stream discards all in-flight samples; the first output after release requires a fresh ival and L enabled cycles.

Optional Feature:
CCSDS_TURBO_DEC_LEXTR_SAT_CNT_EN
- Defined: adds input isop (1 bit, qualified by ival, travels with the sample) and output osat_cnt (16 bit, reset 0).
- When an output sample with sop emerges, osat_cnt loads 1 if that sample saturated, else 0. Otherwise it increments on each saturated valid output, sticking at 0xFFFF.
- Not defined: neither port exists, and no counter logic is built.

Test Plan:
- Defaults, pB_nF=1: istate all 0; igamma[s][0]=-4, igamma[s][1]=4, except igamma[5][1]=20; Lsys=8, Lapri=4, tag=0x3C -> oval exactly 7 cycles later; oLapo=24, oLextr=9, otag=0x3C.
- Wrap: istate all 500, igamma[s][1]=20, igamma[s][0]=0 (sums wrap past +511) -> modular compare gives oLapo=20; Lsys=Lapri=0 -> oLextr=15.
- Saturation: oLapo=200, Lsys=-16, Lapri=-16 -> oLextr=+31. Mirror with oLapo=-200, Lsys=15, Lapri=15 -> -31. With the macro defined, osat_cnt=2 after isop on the first sample.
- pREG_EVERY=2, pSTATE_NUM=64: 20 back-to-back samples with bubbles every 3rd cycle -> latency 6, output order and tags preserved, bubbles reproduced exactly.
- iclkena toggled 0/1 randomly during a stream -> outputs identical to the ungated reference, shifted only by the disabled cycles.
- Assert ireset with 4 samples in flight -> oval=0 and all outputs 0 immediately; no stale output after release.
